down_counter_timer: RTL and testbench

//  Loadable down-counter timer that counts from load_val to zero and pulses done.

---
 rtl/counter_pkg.sv | 23 ++
 rtl/down_counter_timer_if.sv | 27 ++
 rtl/dcnt_prescaler.sv | 32 +++
 rtl/down_counter_timer.sv | 104 ++++++++++
 tb/tb_down_counter_timer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter timer: default width, FSM state
// encoding and the PRESCALE range check used by the prescaler.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic bit prescale_ok(input int p);
    return p >= 1;
  endfunction

  // An out-of-range divider falls back to one tick per clock.
  function automatic int prescale_clamp(input int p);
    return prescale_ok(p) ? p : 1;
  endfunction

endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle between a controller (master) and the down-counter
// timer (slave).
interface down_counter_timer_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] o;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, pause, abort,
    input  o, busy, done
  );

  modport slave (
    input  start, load_val, pause, abort,
    output o, busy, done
  );

endinterface

// File: rtl/dcnt_prescaler.sv
// Clock divider for the down-counter timer: emits a tick every PRESCALE
// un-held clocks, updating on the falling clock edge.
module dcnt_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int PS = prescale_clamp(PRESCALE);
  localparam int PW = (PS > 1) ? $clog2(PS) : 1;
  localparam logic [PW-1:0] LAST = PW'(PS - 1);

  logic [PW-1:0] cnt;

  // With PS=1 the register is stuck at 0 == LAST, so tick is simply !hold.
  assign tick = !hold && (cnt == LAST);

  always_ff @(negedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts load_val to zero and pulses done.
// Define DCNT_AUTORELOAD_EN to reload from load_val after each expiry.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input logic                 clk,
  input logic                 reset,
  down_counter_timer_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             busy_r;
  logic             done_r;
  logic             tick;
  logic             pre_clear;

  // Prescaler restarts from zero whenever a new countdown can begin.
  assign pre_clear = bus.abort || (state == IDLE) || (state == DONE);

  dcnt_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(pre_clear),
    .hold (bus.pause),
    .tick (tick)
  );

  assign bus.o    = count;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  always_ff @(negedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.abort && (state != IDLE)) begin
      state  <= IDLE;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.load_val == '0) begin
              state  <= DONE;
              count  <= '0;
              done_r <= 1'b1;
            end else begin
              state <= RUN;
              count <= bus.load_val;
            end
          end
        end
        // Leaving PAUSE shares the RUN path so a due tick is not lost.
        RUN, PAUSE: begin
          if (bus.pause) begin
            state <= PAUSE;
          end else begin
            state <= RUN;
            if (tick) begin
              if (count == WIDTH'(1)) begin
                count  <= '0;
                done_r <= 1'b1;
                state  <= DONE;
              end else begin
                count <= count - 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_r <= 1'b0;
`ifdef DCNT_AUTORELOAD_EN
          if (bus.load_val != '0) begin
            state <= RUN;
            count <= bus.load_val;
          end else begin
            state  <= IDLE;
            count  <= '0;
            busy_r <= 1'b0;
          end
`else
          state  <= IDLE;
          busy_r <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer with PRESCALE=1 and
// PRESCALE=3 instances; autoreload scenario runs when DCNT_AUTORELOAD_EN is set.
module tb_down_counter_timer;

  logic clk;
  logic reset;
  int   pass_count;
  int   check_count;

  down_counter_timer_if #(.WIDTH(4)) bus1 ();
  down_counter_timer_if #(.WIDTH(4)) bus3 ();

  down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1)
  );

  down_counter_timer #(.WIDTH(4), .PRESCALE(3)) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT updates on negedge; drive and sample 1 time unit after it.
  task automatic next_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_edge();
    next_edge();
    reset = 1'b0;
    next_edge();
    check_count++; if (bus1.o !== 4'd0) $display("[TB] FAIL reset_o: got %0d expected 0", bus1.o); else pass_count++;
    check_count++; if (bus1.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus1.busy); else pass_count++;
    check_count++; if (bus1.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus1.done); else pass_count++;
    check_count++; if (bus3.o !== 4'd0 || bus3.busy !== 1'b0) $display("[TB] FAIL reset_p3: got o=%0d busy=%b expected o=0 busy=0", bus3.o, bus3.busy); else pass_count++;
  endtask

  task automatic test_count();
    logic [3:0] exp_o;
    bus1.load_val = 4'd5;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    bus1.load_val = 4'd7;
    check_count++; if (bus1.o !== 4'd5 || bus1.busy !== 1'b1) $display("[TB] FAIL count_load: got o=%0d busy=%b expected o=5 busy=1", bus1.o, bus1.busy); else pass_count++;
    for (int k = 1; k <= 5; k++) begin
      next_edge();
      exp_o = 4'(5 - k);
      check_count++; if (bus1.o !== exp_o) $display("[TB] FAIL count_o%0d: got %0d expected %0d", k, bus1.o, exp_o); else pass_count++;
      check_count++; if (bus1.done !== (k == 5)) $display("[TB] FAIL count_done%0d: got %b expected %b", k, bus1.done, (k == 5)); else pass_count++;
    end
    check_count++; if (bus1.busy !== 1'b1) $display("[TB] FAIL count_busy_at_done: got %b expected 1", bus1.busy); else pass_count++;
    next_edge();
    check_count++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b0 || bus1.o !== 4'd0) $display("[TB] FAIL count_idle: got o=%0d busy=%b done=%b expected 0/0/0", bus1.o, bus1.busy, bus1.done); else pass_count++;
  endtask

  task automatic test_prescale();
    logic [3:0] exp_o;
    bus3.load_val = 4'd2;
    bus3.start    = 1'b1;
    next_edge();
    bus3.start    = 1'b0;
    check_count++; if (bus3.o !== 4'd2) $display("[TB] FAIL pre_load: got %0d expected 2", bus3.o); else pass_count++;
    for (int k = 1; k <= 6; k++) begin
      next_edge();
      exp_o = (k < 3) ? 4'd2 : (k < 6) ? 4'd1 : 4'd0;
      check_count++; if (bus3.o !== exp_o) $display("[TB] FAIL pre_o%0d: got %0d expected %0d", k, bus3.o, exp_o); else pass_count++;
      check_count++; if (bus3.done !== (k == 6)) $display("[TB] FAIL pre_done%0d: got %b expected %b", k, bus3.done, (k == 6)); else pass_count++;
    end
    next_edge();
    check_count++; if (bus3.done !== 1'b0 || bus3.busy !== 1'b0) $display("[TB] FAIL pre_idle: got busy=%b done=%b expected 0/0", bus3.busy, bus3.done); else pass_count++;
  endtask

  task automatic test_pause();
    logic [3:0] exp_o;
    bus1.load_val = 4'd15;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    for (int k = 1; k <= 3; k++) next_edge();
    check_count++; if (bus1.o !== 4'd12) $display("[TB] FAIL pause_pre: got %0d expected 12", bus1.o); else pass_count++;
    bus1.pause = 1'b1;
    for (int k = 4; k <= 7; k++) begin
      next_edge();
      check_count++; if (bus1.o !== 4'd12 || bus1.busy !== 1'b1) $display("[TB] FAIL pause_hold%0d: got o=%0d busy=%b expected o=12 busy=1", k, bus1.o, bus1.busy); else pass_count++;
    end
    bus1.pause = 1'b0;
    for (int k = 8; k <= 19; k++) begin
      bus1.start    = (k == 10);
      bus1.load_val = (k == 10) ? 4'd3 : 4'd15;
      next_edge();
      exp_o = 4'(19 - k);
      check_count++; if (bus1.o !== exp_o) $display("[TB] FAIL pause_o%0d: got %0d expected %0d", k, bus1.o, exp_o); else pass_count++;
      check_count++; if (bus1.done !== (k == 19)) $display("[TB] FAIL pause_done%0d: got %b expected %b", k, bus1.done, (k == 19)); else pass_count++;
    end
    bus1.start = 1'b0;
    next_edge();
    check_count++; if (bus1.busy !== 1'b0) $display("[TB] FAIL pause_idle: got busy=%b expected 0", bus1.busy); else pass_count++;
  endtask

  task automatic test_zero_load();
    bus1.load_val = 4'd0;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    check_count++; if (bus1.done !== 1'b1 || bus1.o !== 4'd0 || bus1.busy !== 1'b1) $display("[TB] FAIL zero_done: got o=%0d busy=%b done=%b expected 0/1/1", bus1.o, bus1.busy, bus1.done); else pass_count++;
    next_edge();
    check_count++; if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) $display("[TB] FAIL zero_idle: got busy=%b done=%b expected 0/0", bus1.busy, bus1.done); else pass_count++;
  endtask

  task automatic test_abort();
    bus1.load_val = 4'd9;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    for (int k = 1; k <= 5; k++) next_edge();
    check_count++; if (bus1.o !== 4'd4) $display("[TB] FAIL abort_pre: got %0d expected 4", bus1.o); else pass_count++;
    bus1.abort = 1'b1;
    next_edge();
    bus1.abort = 1'b0;
    check_count++; if (bus1.o !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) $display("[TB] FAIL abort_now: got o=%0d busy=%b done=%b expected 0/0/0", bus1.o, bus1.busy, bus1.done); else pass_count++;
    for (int k = 0; k < 5; k++) begin
      next_edge();
      check_count++; if (bus1.done !== 1'b0 || bus1.o !== 4'd0) $display("[TB] FAIL abort_after%0d: got o=%0d done=%b expected 0/0", k, bus1.o, bus1.done); else pass_count++;
    end
  endtask

  task automatic test_reset_mid();
    bus1.load_val = 4'd9;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    next_edge();
    next_edge();
    check_count++; if (bus1.o !== 4'd7) $display("[TB] FAIL rmid_pre: got %0d expected 7", bus1.o); else pass_count++;
    reset = 1'b1;
    next_edge();
    reset = 1'b0;
    check_count++; if (bus1.o !== 4'd0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) $display("[TB] FAIL rmid_now: got o=%0d busy=%b done=%b expected 0/0/0", bus1.o, bus1.busy, bus1.done); else pass_count++;
  endtask

`ifdef DCNT_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [3:0] exp_o;
    bus1.load_val = 4'd3;
    bus1.start    = 1'b1;
    next_edge();
    bus1.start    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      next_edge();
      exp_o = 4'(3 - (k % 4));
      check_count++; if (bus1.o !== exp_o) $display("[TB] FAIL arl_o%0d: got %0d expected %0d", k, bus1.o, exp_o); else pass_count++;
      check_count++; if (bus1.done !== (k % 4 == 3)) $display("[TB] FAIL arl_done%0d: got %b expected %b", k, bus1.done, (k % 4 == 3)); else pass_count++;
      check_count++; if (bus1.busy !== 1'b1) $display("[TB] FAIL arl_busy%0d: got %b expected 1", k, bus1.busy); else pass_count++;
    end
    reset = 1'b1;
    next_edge();
    reset = 1'b0;
    check_count++; if (bus1.o !== 4'd0 || bus1.busy !== 1'b0) $display("[TB] FAIL arl_reset: got o=%0d busy=%b expected 0/0", bus1.o, bus1.busy); else pass_count++;
  endtask
`endif

  initial begin
    pass_count    = 0;
    check_count   = 0;
    reset         = 1'b1;
    bus1.start    = 1'b0;
    bus1.load_val = 4'd0;
    bus1.pause    = 1'b0;
    bus1.abort    = 1'b0;
    bus3.start    = 1'b0;
    bus3.load_val = 4'd0;
    bus3.pause    = 1'b0;
    bus3.abort    = 1'b0;

    test_reset();
    test_count();
    test_prescale();
    test_pause();
    test_zero_load();
    test_abort();
    test_reset_mid();
`ifdef DCNT_AUTORELOAD_EN
    test_autoreload();
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
